// File: rtl/fp32_to_fixed.sv
// fp32_to_fixed: IEEE-754 single precision to signed two's-complement fixed point.
// Two pipeline registers (unpack, then shift/saturate) with valid/ready on both
// sides. Both stages advance together on en, so a stall freezes the whole pipe.
module fp32_to_fixed #(
  parameter int OUT_W  = 32,
  parameter int FRAC_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_nan
);

  // Shift amounts span roughly -150..+151, so 10 signed bits are enough.
  localparam int SH_W = 10;
  localparam logic signed [SH_W-1:0] SH_BIAS = SH_W'(150 - FRAC_W);
  // Largest left shift that still fits a 24-bit mantissa in OUT_W+1 bits.
  localparam logic signed [SH_W-1:0] SH_MAX  = SH_W'(OUT_W - 23);
  // Right shifts of 24 or more leave nothing of the mantissa.
  localparam logic signed [SH_W-1:0] SH_GONE = SH_W'(24);
  localparam logic [OUT_W:0]   POS_LIM = {2'b00, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W:0]   NEG_LIM = {2'b01, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] POS_SAT = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] NEG_SAT = {1'b1, {(OUT_W-1){1'b0}}};

  logic en;

  logic                   s1_valid_reg;
  logic                   s1_sign_reg;
  logic                   s1_nan_reg;
  logic                   s1_inf_reg;
  logic [23:0]            s1_m_reg;
  logic signed [SH_W-1:0] s1_sh_reg;

  logic                   out_valid_reg;
  logic [OUT_W-1:0]       out_data_reg;
  logic                   out_ovf_reg;
  logic                   out_nan_reg;

  logic [7:0]             in_exp;
  logic [22:0]            in_frac;
  logic                   exp_is_max;
  logic [23:0]            m_next;
  logic signed [SH_W-1:0] sh_next;

  logic [OUT_W:0]         m_ext;
  logic [OUT_W:0]         mag;
  logic                   too_big;
  logic signed [SH_W-1:0] neg_sh;
  logic [OUT_W-1:0]       data_next;
  logic                   ovf_next;
  logic                   nan_next;

  // The pipe advances when the output register is empty or being drained.
  assign en       = !out_valid_reg || out_ready;
  assign in_ready = !rst && en;

  assign in_exp     = in_data[30:23];
  assign in_frac    = in_data[22:0];
  assign exp_is_max = &in_exp;

  // Unpack: restore the hidden bit for normal numbers; zero/subnormal and
  // Inf/NaN carry a zero mantissa, so later stages see an exact 0 for them.
  always_comb begin
    m_next  = ((in_exp != 8'd0) && !exp_is_max) ? {1'b1, in_frac} : 24'd0;
    sh_next = $signed({2'b00, in_exp}) - SH_BIAS;
  end

  // Stage 1 register: unpacked fields and the signed shift amount.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_sign_reg  <= 1'b0;
      s1_nan_reg   <= 1'b0;
      s1_inf_reg   <= 1'b0;
      s1_m_reg     <= 24'd0;
      s1_sh_reg    <= '0;
    end else if (en) begin
      s1_valid_reg <= in_valid;
      s1_sign_reg  <= in_data[31];
      s1_nan_reg   <= exp_is_max && (in_frac != 23'd0);
      s1_inf_reg   <= exp_is_max && (in_frac == 23'd0);
      s1_m_reg     <= m_next;
      s1_sh_reg    <= sh_next;
    end
  end

  // Denormalise the mantissa and saturate by sign; oversized left shifts are
  // flagged without shifting so the shifter never needs more than OUT_W+1 bits.
  always_comb begin
    m_ext     = {{(OUT_W-23){1'b0}}, s1_m_reg};
    mag       = '0;
    too_big   = 1'b0;
    neg_sh    = -s1_sh_reg;
    data_next = '0;
    ovf_next  = 1'b0;
    nan_next  = 1'b0;
    if (!s1_sh_reg[SH_W-1]) begin
      if (s1_sh_reg > SH_MAX) too_big = 1'b1;
      else                    mag     = m_ext << s1_sh_reg;
    end else if (neg_sh < SH_GONE) begin
      mag = m_ext >> neg_sh;
    end
    if (s1_nan_reg) begin
      nan_next = 1'b1;
    end else if (s1_inf_reg || too_big ||
                 (s1_sign_reg ? (mag > NEG_LIM) : (mag > POS_LIM))) begin
      data_next = s1_sign_reg ? NEG_SAT : POS_SAT;
      ovf_next  = 1'b1;
    end else begin
      // mag == 2^(OUT_W-1) on a negative input negates to the most negative code.
      data_next = s1_sign_reg ? -mag[OUT_W-1:0] : mag[OUT_W-1:0];
    end
  end

  // Stage 2 register: the result word and its sideband flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ovf_reg   <= 1'b0;
      out_nan_reg   <= 1'b0;
    end else if (en) begin
      out_valid_reg <= s1_valid_reg;
      out_data_reg  <= data_next;
      out_ovf_reg   <= ovf_next;
      out_nan_reg   <= nan_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ovf   = out_ovf_reg;
  assign out_nan   = out_nan_reg;

endmodule

// File: tb/tb_fp32_to_fixed.sv
// tb_fp32_to_fixed: scoreboard bench for fp32_to_fixed (OUT_W=32, FRAC_W=16).
// The driver pushes the expected result on every accepted sample; an independent
// monitor pops and compares whenever an output transfers.
module tb_fp32_to_fixed;

  typedef struct packed {
    logic [31:0] d;
    logic        ovf;
    logic        nan;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_nan;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   ready_mode = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random, 3: never
  int   pat_idx = 0;

  fp32_to_fixed #(.OUT_W(32), .FRAC_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_nan(out_nan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end else begin
      $display("[TB] ok %s: %h", name, act);
    end
  endtask

  // Reference: evaluate the float as a real number, scale by 2^16, truncate
  // toward zero, then clamp to the signed 32-bit range.
  function automatic exp_t model(input logic [31:0] x);
    exp_t r;
    real  v;
    real  t;
    longint q;
    int   e;
    r = '0;
    e = int'(x[30:23]);
    if (e == 255) begin
      if (x[22:0] != 23'd0) r.nan = 1'b1;
      else begin
        r.ovf = 1'b1;
        r.d   = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      return r;
    end
    if (e == 0) return r;
    v = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (e - 127)) * 65536.0;
    t = $floor(v);
    if (!x[31] && t > 2147483647.0) begin
      r.ovf = 1'b1; r.d = 32'h7FFF_FFFF;
    end else if (x[31] && t > 2147483648.0) begin
      r.ovf = 1'b1; r.d = 32'h8000_0000;
    end else begin
      q = longint'(t);
      if (x[31]) q = -q;
      r.d = q[31:0];
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_fp();
    int r;
    logic [7:0] e;
    logic [31:0] f;
    r = $urandom_range(0, 9);
    f = $urandom;
    if (r == 0)      e = 8'd0;
    else if (r == 1) e = 8'd255;
    else if (r == 2) e = 8'd142;           // right at the 2^31 boundary
    else             e = 8'($urandom_range(100, 180));
    if (r == 1 && f[0]) f[22:0] = 23'd0;    // Inf as often as NaN
    return {1'($urandom_range(0, 1)), e, f[22:0]};
  endfunction

  task automatic set_ready();
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
        pat_idx++;
      end
      2: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  endtask

  task automatic send(input logic [31:0] x, input exp_t e);
    int budget;
    budget = 0;
    forever begin
      @(negedge clk);
      set_ready();
      in_valid = 1'b1;
      in_data  = x;
      #1;
      if (in_ready) begin
        sb.push_back(e);
        break;
      end
      budget++;
      if (budget > 100) begin
        tests++; fails++;
        $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", budget);
        break;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    set_ready();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int b;
    ready_mode = 0;
    b = 0;
    while (sb.size() != 0 && b < 200) begin
      idle();
      b++;
    end
    idle();
    idle();
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d outputs outstanding, required 0", sb.size());
    end
  endtask

  // Monitor: handshake relation, stall stability and scoreboard comparison.
  initial begin
    bit          stalled;
    logic [33:0] held;
    exp_t        e;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stalled = 1'b0;
        continue;
      end
      chk("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (stalled)
        chk("stall_hold", 64'({out_valid, out_data, out_ovf, out_nan}), 64'({1'b1, held}));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output: got %h with empty scoreboard, required none", out_data);
        end else begin
          e = sb.pop_front();
          chk("data", 64'(out_data), 64'(e.d));
          chk("flags", 64'({out_ovf, out_nan}), 64'({e.ovf, e.nan}));
        end
      end
      stalled = out_valid && !out_ready;
      held    = {out_data, out_ovf, out_nan};
    end
  end

  logic [31:0] dir_in [0:8];
  logic [33:0] dir_ex [0:8];

  initial begin
    logic [31:0] x;
    dir_in[0] = 32'h3F40_0000; dir_ex[0] = {32'h0000_C000, 2'b00};
    dir_in[1] = 32'hC020_0000; dir_ex[1] = {32'hFFFD_8000, 2'b00};
    dir_in[2] = 32'h8000_0000; dir_ex[2] = {32'h0000_0000, 2'b00};
    dir_in[3] = 32'h471C_4000; dir_ex[3] = {32'h7FFF_FFFF, 2'b10};
    dir_in[4] = 32'hC700_0000; dir_ex[4] = {32'h8000_0000, 2'b00};
    dir_in[5] = 32'h7F80_0000; dir_ex[5] = {32'h7FFF_FFFF, 2'b10};
    dir_in[6] = 32'h7FC0_0000; dir_ex[6] = {32'h0000_0000, 2'b01};
    dir_in[7] = 32'h3580_0000; dir_ex[7] = {32'h0000_0000, 2'b00};
    dir_in[8] = 32'hFF80_0000; dir_ex[8] = {32'h8000_0000, 2'b10};

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_flags", 64'({out_ovf, out_nan}), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;

    // Latency: presented in cycle N, out_valid low in N+1, high in N+2.
    ready_mode = 0;
    send(32'h3F80_0000, '{d: 32'h0001_0000, ovf: 1'b0, nan: 1'b0});
    idle(); #1;
    chk("latency_n1", 64'(out_valid), 64'(0));
    idle(); #1;
    chk("latency_n2", 64'(out_valid), 64'(1));

    // Directed values, back to back.
    for (int i = 0; i < 9; i++) send(dir_in[i], exp_t'(dir_ex[i]));
    drain();

    // 8 samples under the 1,0,0,1 ready pattern.
    ready_mode = 1;
    pat_idx = 0;
    for (int i = 0; i < 8; i++) begin
      x = rand_fp();
      send(x, model(x));
    end
    ready_mode = 1;
    for (int i = 0; i < 8; i++) idle();
    drain();

    // Reset with two samples in flight, output stalled.
    ready_mode = 3;
    send(32'h4000_0000, model(32'h4000_0000));
    send(32'h4040_0000, model(32'h4040_0000));
    idle();
    idle();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    ready_mode = 0;
    send(32'h4080_0000, '{d: 32'h0004_0000, ovf: 1'b0, nan: 1'b0});
    drain();

    // Randomised stream with random backpressure.
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      x = rand_fp();
      send(x, model(x));
      if ($urandom_range(0, 4) == 0) idle();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
